// File: rtl/alu_writeback.sv
// alu_writeback: commits ALU results to the register file write port and owns SREG
module alu_writeback #(
  parameter logic [7:0] SREG_INIT = 8'h00,
  parameter logic [4:0] MUL_BASE  = 5'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mode,
  input  logic [4:0]  dst,
  input  logic [7:0]  res8,
  input  logic [15:0] res16,
  input  logic [7:0]  flags,
  input  logic        sreg_we,
  input  logic [7:0]  sreg_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [7:0]  rf_data,
  output logic [7:0]  sreg,
  output logic        busy
);
  typedef enum logic {IDLE, HIGH} state_t;
  state_t     state_q, state_d;
  logic       rf_we_q, rf_we_d;
  logic [4:0] rf_addr_q, rf_addr_d, hi_addr_q, hi_addr_d, base;
  logic [7:0] rf_data_q, rf_data_d, sreg_q, sreg_d, hi_data_q, hi_data_d;
  logic       accept, w8f, w8, fo, w16d, w16m, w16;
  assign in_ready = state_q == IDLE;
  assign busy     = state_q == HIGH;
  assign accept   = in_valid & in_ready;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign sreg     = sreg_q;
  assign w8f  = mode inside {5'd2, 5'd3, [5'd6:5'd10], [5'd12:5'd13], [5'd15:5'd19]};
  assign w8   = mode inside {5'd0, 5'd14, 5'd22};
  assign fo   = mode inside {5'd1, 5'd5, 5'd11};
  assign w16d = mode inside {5'd20, 5'd21};
  assign w16m = mode inside {[5'd23:5'd25]};
  assign w16  = w16d | w16m;
  assign base = w16m ? MUL_BASE : dst;
  always_comb begin
    state_d   = state_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    sreg_d    = sreg_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    if (state_q == HIGH) begin
      state_d   = IDLE;
      rf_we_d   = 1'b1;
      rf_addr_d = hi_addr_q;
      rf_data_d = hi_data_q;
    end else if (accept) begin
      rf_we_d   = w8 | w8f | w16;
      rf_addr_d = base;
      rf_data_d = w16 ? res16[7:0] : res8;
      sreg_d    = (w8f | fo | w16) ? flags : sreg_q;
      hi_addr_d = w16 ? base + 5'd1 : hi_addr_q;
      hi_data_d = w16 ? res16[15:8] : hi_data_q;
      state_d   = w16 ? HIGH : IDLE;
    end
    // I/O writes to SREG take priority over flags from the ALU
    if (sreg_we) sreg_d = sreg_wdata;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 8'h00;
      sreg_q    <= SREG_INIT;
      hi_addr_q <= 5'd0;
      hi_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      sreg_q    <= sreg_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
    end
  end
endmodule
